// File: rtl/smem_pkg.sv
// Shared definitions for the occurrence-line fetch path: count layout,
// line geometry and the issue FSM state encoding.
package smem_pkg;

  localparam int OCC_CNT_W  = 384;
  localparam int CNT_A_W    = 32;
  localparam int CNT_B_W    = 64;
  localparam int CNT_A_LSB  = 0;
  localparam int CNT_B_LSB  = 128;
  localparam int DEF_LINE_W = 512;
  localparam int LINE_OFS_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_K = 2'd1,
    ISSUE_L = 2'd2
  } fetch_state_e;

  // Pull the four 32-bit A counts and four 64-bit B counts out of the low
  // part of a line, packed {b3..b0, a3..a0}. The packing matches the line
  // layout, so this is written field-by-field to keep the layout explicit.
  function automatic logic [OCC_CNT_W-1:0] extract_counts(input logic [OCC_CNT_W-1:0] low);
    logic [OCC_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[CNT_A_LSB + i*CNT_A_W +: CNT_A_W] = low[CNT_A_LSB + i*CNT_A_W +: CNT_A_W];
      c[CNT_B_LSB + i*CNT_B_W +: CNT_B_W] = low[CNT_B_LSB + i*CNT_B_W +: CNT_B_W];
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. rd_data is the head entry, peek_data the
// entry behind it (valid when multi). A write while full is accepted only
// together with a read. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] peek_data,
  output logic             empty,
  output logic             full,
  output logic             multi
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign multi     = (count >= (AW+1)'(2));
  assign do_rd     = rd_en && !empty;
  assign do_wr     = wr_en && (!full || do_rd);
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign rd_data   = mem[rd_ptr];
  assign peek_data = mem[rd_ptr_nx];

  // Storage is data-only; validity comes from the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr_nx;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bwt_occ_fetch.sv
// Occurrence-count fetch stage: turns each K/L request pair into two line
// reads, pairs up the in-order responses and hands {tag, cnt_k, cnt_l} on.
// Credits bound the number of pairs in flight so responses never stall.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no pending pair; mem_rd_valid low, mem_rd_addr zero
//  ISSUE_K | presenting head pair's K line address, waiting for ready
//  ISSUE_L | presenting head pair's L line address, waiting for ready
module bwt_occ_fetch
  import smem_pkg::*;
#(
  parameter int ADDR_W = 42,
  parameter int TAG_W  = 9,
  parameter int DEPTH  = 8,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr_k,
  input  logic [ADDR_W-1:0]    req_addr_l,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 mem_rd_valid,
  input  logic                 mem_rd_ready,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_rsp_valid,
  input  logic [LINE_W-1:0]    mem_rsp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [OCC_CNT_W-1:0] out_cnt_k,
  output logic [OCC_CNT_W-1:0] out_cnt_l
);

  localparam int REQ_W  = TAG_W + 2*ADDR_W;
  localparam int OUT_W  = TAG_W + 2*OCC_CNT_W;
  localparam int CRED_W = $clog2(DEPTH + 1);

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
  endfunction

  fetch_state_e state_q, state_nxt;

  logic [CRED_W-1:0]    credits_q, credits_nxt;
  logic                 req_ready_q;
  logic                 req_acc;
  logic                 out_hs;

  logic [REQ_W-1:0]     req_head, req_peek;
  logic                 req_empty, req_full, req_multi, req_pop;
  logic [ADDR_W-1:0]    head_k, head_l, peek_k;
  logic [TAG_W-1:0]     head_tag;

  logic                 rd_valid_nxt;
  logic [ADDR_W-1:0]    rd_addr_nxt;

  logic                 tag_push;
  logic [TAG_W-1:0]     tag_head, tag_peek;
  logic                 tag_empty, tag_full, tag_multi;

  logic                 phase_q;
  logic                 k_rsp, l_rsp;
  logic [OCC_CNT_W-1:0] k_hold;
  logic [OCC_CNT_W-1:0] rsp_cnt;

  logic [OUT_W-1:0]     out_head, out_peek;
  logic                 out_empty, out_full, out_multi;

  logic                 unused_sigs;

  assign req_ready = req_ready_q;
  assign req_acc   = req_valid && req_ready_q;
  assign out_hs    = out_valid && out_ready;

  // Credit update: take one per accepted pair, return one per delivered pair.
  always_comb begin
    credits_nxt = credits_q;
    if (req_acc && !out_hs)      credits_nxt = credits_q - 1'b1;
    else if (!req_acc && out_hs) credits_nxt = credits_q + 1'b1;
  end

  // Credit register; req_ready is registered from the next credit value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q   <= CRED_W'(DEPTH);
      req_ready_q <= 1'b0;
    end else begin
      credits_q   <= credits_nxt;
      req_ready_q <= (credits_nxt != '0);
    end
  end

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (req_acc),
    .wr_data   ({req_tag, req_addr_l, req_addr_k}),
    .rd_en     (req_pop),
    .rd_data   (req_head),
    .peek_data (req_peek),
    .empty     (req_empty),
    .full      (req_full),
    .multi     (req_multi)
  );

  assign head_k   = req_head[ADDR_W-1:0];
  assign head_l   = req_head[2*ADDR_W-1:ADDR_W];
  assign head_tag = req_head[REQ_W-1:2*ADDR_W];
  assign peek_k   = req_peek[ADDR_W-1:0];

  // Issue FSM next state. The next address is computed here so the port is
  // driven straight from flops; a pair accepted while idle (or while the
  // last queued pair is retiring) is bypassed so K issues one cycle later.
  always_comb begin
    state_nxt    = state_q;
    rd_valid_nxt = mem_rd_valid;
    rd_addr_nxt  = mem_rd_addr;
    req_pop      = 1'b0;
    tag_push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!req_empty) begin
          state_nxt    = ISSUE_K;
          rd_valid_nxt = 1'b1;
          rd_addr_nxt  = line_addr(head_k);
        end else if (req_acc) begin
          state_nxt    = ISSUE_K;
          rd_valid_nxt = 1'b1;
          rd_addr_nxt  = line_addr(req_addr_k);
        end
      end
      ISSUE_K: begin
        if (mem_rd_ready) begin
          state_nxt   = ISSUE_L;
          rd_addr_nxt = line_addr(head_l);
        end
      end
      ISSUE_L: begin
        if (mem_rd_ready) begin
          req_pop  = 1'b1;
          tag_push = 1'b1;
          if (req_multi) begin
            state_nxt   = ISSUE_K;
            rd_addr_nxt = line_addr(peek_k);
          end else if (req_acc) begin
            state_nxt   = ISSUE_K;
            rd_addr_nxt = line_addr(req_addr_k);
          end else begin
            state_nxt    = IDLE;
            rd_valid_nxt = 1'b0;
            rd_addr_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        rd_valid_nxt = 1'b0;
        rd_addr_nxt  = '0;
      end
    endcase
  end

  // Issue FSM state and read-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
    end else begin
      state_q      <= state_nxt;
      mem_rd_valid <= rd_valid_nxt;
      mem_rd_addr  <= rd_addr_nxt;
    end
  end

  sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (tag_push),
    .wr_data   (head_tag),
    .rd_en     (l_rsp),
    .rd_data   (tag_head),
    .peek_data (tag_peek),
    .empty     (tag_empty),
    .full      (tag_full),
    .multi     (tag_multi)
  );

  assign k_rsp   = mem_rsp_valid && !phase_q;
  assign l_rsp   = mem_rsp_valid && phase_q;
  assign rsp_cnt = extract_counts(mem_rsp_data[OCC_CNT_W-1:0]);

  // Response collector: park the K counts until the matching L line lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      k_hold  <= '0;
    end else begin
      if (mem_rsp_valid) phase_q <= !phase_q;
      if (k_rsp)         k_hold  <= rsp_cnt;
    end
  end

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (l_rsp),
    .wr_data   ({tag_head, k_hold, rsp_cnt}),
    .rd_en     (out_hs),
    .rd_data   (out_head),
    .peek_data (out_peek),
    .empty     (out_empty),
    .full      (out_full),
    .multi     (out_multi)
  );

  // Output fields read zero whenever nothing is presented.
  assign out_valid = !out_empty;
  assign out_tag   = out_empty ? '0 : out_head[OUT_W-1:2*OCC_CNT_W];
  assign out_cnt_k = out_empty ? '0 : out_head[2*OCC_CNT_W-1:OCC_CNT_W];
  assign out_cnt_l = out_empty ? '0 : out_head[OCC_CNT_W-1:0];

  assign unused_sigs = ^{tag_peek, tag_multi, out_peek, out_multi,
                         req_peek[REQ_W-1:ADDR_W], mem_rsp_data[LINE_W-1:OCC_CNT_W]};

  a_rsp_without_tag: assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid && !phase_q && tag_empty));
  a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    !(tag_push && tag_full));
  a_req_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_acc && req_full));
  a_out_overflow: assert property (@(posedge clk) disable iff (rst)
    !(l_rsp && out_full && !out_hs));

endmodule

// File: tb/tb_bwt_occ_fetch.sv
module tb_bwt_occ_fetch;

  localparam int ADDR_W = 42;
  localparam int TAG_W  = 9;
  localparam int DEPTH  = 8;
  localparam int LINE_W = 512;
  localparam int CNT_W  = 384;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr_k = '0;
  logic [ADDR_W-1:0] req_addr_l = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              mem_rd_valid;
  logic              mem_rd_ready = 1'b1;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [LINE_W-1:0] mem_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [TAG_W-1:0]  out_tag;
  logic [CNT_W-1:0]  out_cnt_k;
  logic [CNT_W-1:0]  out_cnt_l;

  bwt_occ_fetch #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr_k    (req_addr_k),
    .req_addr_l    (req_addr_l),
    .req_tag       (req_tag),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_tag       (out_tag),
    .out_cnt_k     (out_cnt_k),
    .out_cnt_l     (out_cnt_l)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [TAG_W-1:0] tag; logic [ADDR_W-1:0] ak; logic [ADDR_W-1:0] al; } pair_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [CNT_W-1:0] k; logic [CNT_W-1:0] l; } outrec_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] ak;
    logic [ADDR_W-1:0] al;
    logic [ADDR_W-1:0] exp_k;
    logic [ADDR_W-1:0] exp_l;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_iss = 0;
  int rsp_lat = 3;
  int rsp_gap = 0;
  int last_due = 0;
  int d_tmp;

  pair_t   acc_log[$];
  outrec_t out_log[$];
  pend_t   pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory line content derived from the line index only.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] ln;
    logic [31:0] base;
    base = a[37:6] * 32'h9E37_79B1;
    for (int i = 0; i < 16; i++) ln[i*32 +: 32] = base + 32'(i) * 32'h0101_0101;
    return ln;
  endfunction

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors and memory model, all sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if (req_valid && req_ready) begin
        acc_log.push_back('{req_tag, req_addr_k, req_addr_l});
        n_acc++;
      end
      if (out_valid && out_ready) begin
        out_log.push_back('{out_tag, out_cnt_k, out_cnt_l});
        n_out++;
      end
      if (mem_rd_valid && mem_rd_ready) begin
        d_tmp = cyc + rsp_lat;
        if (d_tmp <= last_due) d_tmp = last_due + 1;
        if (rsp_gap > 0) d_tmp = d_tmp + $urandom_range(rsp_gap, 0);
        last_due = d_tmp;
        pend.push_back('{mem_rd_addr, d_tmp});
        n_iss++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = line_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  task automatic set_fields(input int t);
    req_tag    = TAG_W'(t);
    req_addr_k = {10'd0, 26'(t), 6'h13};
    req_addr_l = {10'h2A5, 26'(t), 6'h2C};
  endtask

  task automatic send_stream(input int n, input int base, input int max_cyc, input bit keep);
    int got;
    int k;
    int a0;
    got = 0;
    k = 0;
    a0 = n_acc;
    set_fields(base);
    req_valid = 1'b1;
    while (got < n && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
      if (n_acc - a0 != got) begin
        got = n_acc - a0;
        set_fields(base + got);
      end
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (out_log.size() < n) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s timeout: got %0d outputs, needed %0d", nm, out_log.size(), n);
    end
  endtask

  task automatic sb_check(input string nm, input int n);
    pair_t p;
    outrec_t o;
    logic [LINE_W-1:0] lk;
    logic [LINE_W-1:0] ll;
    chk({nm, "_count"}, out_log.size(), n);
    while (out_log.size() > 0 && acc_log.size() > 0) begin
      p  = acc_log.pop_front();
      o  = out_log.pop_front();
      lk = line_of(p.ak);
      ll = line_of(p.al);
      chk({nm, "_tag"}, o.tag, p.tag);
      chk({nm, "_cnt_k"}, o.k, lk[CNT_W-1:0]);
      chk({nm, "_cnt_l"}, o.l, ll[CNT_W-1:0]);
    end
    acc_log.delete();
    out_log.delete();
  endtask

  initial begin
    #500000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];
  int a0, i0;
  logic [LINE_W-1:0] tl;

  initial begin
    vecs[0] = '{9'd5,   42'h40,          42'h80,          42'h40,          42'h80};
    vecs[1] = '{9'h1FF, 42'h3FF_FFFF_FFFF, 42'h0,         42'h3FF_FFFF_FFC0, 42'h0};
    vecs[2] = '{9'h0AA, 42'h12345,       42'h2A_BCDE_F017, 42'h12340,       42'h2A_BCDE_F000};
    vecs[3] = '{9'h000, 42'h1000,        42'h103F,        42'h1000,        42'h1000};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_rd_valid", mem_rd_valid, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_cnt_k", out_cnt_k, 0);
    chk("rst_out_cnt_l", out_cnt_l, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("req_ready_after_rst", req_ready, 1);

    // Table-driven single pairs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_tag    = vecs[i].tag;
      req_addr_k = vecs[i].ak;
      req_addr_l = vecs[i].al;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("vec_issue_k", {mem_rd_valid, mem_rd_addr}, {1'b1, vecs[i].exp_k});
      @(negedge clk);
      chk("vec_issue_l", {mem_rd_valid, mem_rd_addr}, {1'b1, vecs[i].exp_l});
      wait_out("vec_out", 1, 60);
      if (out_log.size() > 0) begin
        chk("vec_tag", out_log[0].tag, vecs[i].tag);
        tl = line_of(vecs[i].exp_k);
        chk("vec_cnt_k", out_log[0].k, tl[CNT_W-1:0]);
        tl = line_of(vecs[i].exp_l);
        chk("vec_cnt_l", out_log[0].l, tl[CNT_W-1:0]);
      end
      acc_log.delete();
      out_log.delete();
    end

    // Fill to credit limit with the consumer stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    a0 = n_acc;
    i0 = n_iss;
    send_stream(20, 16, 40, 1'b1);
    @(negedge clk);
    chk("fill_accepts", n_acc - a0, 8);
    chk("fill_req_ready_low", req_ready, 0);
    chk("fill_reads", n_iss - i0, 16);
    chk("fill_out_valid", out_valid, 1);
    // One delivery with req_valid still high: exactly one more accept
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("credit_return_ready", req_ready, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("fill_one_more", n_acc - a0, 9);
    chk("fill_req_ready_low2", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    wait_out("fill_drain", 9, 100);
    sb_check("fill", 9);

    // Memory back-pressure while K is presented
    @(posedge clk); #1;
    mem_rd_ready = 1'b0;
    req_tag    = 9'd3;
    req_addr_k = 42'h5000;
    req_addr_l = 42'h6040;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {mem_rd_valid, mem_rd_addr}, {1'b1, 42'h5000});
    end
    @(posedge clk); #1;
    mem_rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_pre_handshake", {mem_rd_valid, mem_rd_addr}, {1'b1, 42'h5000});
    @(negedge clk);
    chk("bp_issue_l", {mem_rd_valid, mem_rd_addr}, {1'b1, 42'h6040});
    wait_out("bp_out", 1, 60);
    sb_check("bp", 1);

    // Ordering with irregular response gaps
    rsp_gap = 5;
    @(posedge clk); #1;
    send_stream(3, 1, 20, 1'b0);
    wait_out("order_out", 3, 300);
    sb_check("order", 3);
    rsp_gap = 0;

    // Reset with pairs outstanding
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_stream(3, 40, 20, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_mem_rd_valid", mem_rd_valid, 0);
    chk("midrst_mem_rd_addr", mem_rd_addr, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_tag", out_tag, 0);
    chk("midrst_out_cnt_k", out_cnt_k, 0);
    repeat (2) @(negedge clk);
    acc_log.delete();
    out_log.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_after", req_ready, 1);
    a0 = n_acc;
    send_stream(12, 60, 30, 1'b1);
    @(negedge clk);
    chk("midrst_credits", n_acc - a0, 8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    wait_out("midrst_drain", 8, 100);
    sb_check("midrst", 8);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
